screen_pixel_fetch: RTL and testbench

Pixel source for the VGA display controller: converts the controller's linear pixel address into reads of the 512x256 1-bpp screen memory (16-bit words, 32 words per row), prefetching one word ahead. Returns an RGB565 colour per pixel. The Hack screen is centred in the 640x480 raster, and everything outside it is drawn in a border colour. Sits between screen RAM and the display controller, replacing the fixed test-pattern generator.

---
 rtl/screen_pixel_fetch.sv | 185 ++++++++++++++++++
 tb/tb_screen_pixel_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/screen_pixel_fetch.sv
// screen_pixel_fetch
// Turns the display controller's pixel strobes into 1-bpp screen-memory reads
// and an RGB565 colour per pixel. The screen window sits inside the raster;
// anything outside it is drawn in the border colour. One word is prefetched
// ahead of the word currently being shifted out.
//
// Fetch FSM states:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for the prefetch slot to empty on an active row
//   ST_REQ   | mem_rd asserted with mem_addr = next word address
//   ST_CAP   | mem_data valid; latch it into the prefetch slot
module screen_pixel_fetch #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          WIN_X    = 64,
  parameter int          WIN_Y    = 112,
  parameter int          WIN_W    = 512,
  parameter int          WIN_H    = 256,
  parameter logic [15:0] FG       = 16'h0000,
  parameter logic [15:0] BG       = 16'hFFFF,
  parameter logic [15:0] BORDER   = 16'h001F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_stb,
  input  logic [23:0] pix_addr,
  output logic [12:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  output logic [15:0] color,
  output logic        underrun
);

  localparam logic [9:0] H_MAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_MAX = 10'(V_ACTIVE - 1);
  localparam logic [9:0] X_LO  = 10'(WIN_X);
  localparam logic [9:0] X_HI  = 10'(WIN_X + WIN_W);
  localparam logic [9:0] Y_LO  = 10'(WIN_Y);
  localparam logic [9:0] Y_HI  = 10'(WIN_Y + WIN_H);
  localparam logic [5:0] WORDS = 6'(WIN_W / 16);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic [12:0] next_addr_q, next_addr_d;
  logic [15:0] next_word_q, next_word_d;
  logic        next_valid_q, next_valid_d;
  logic [15:0] cur_word_q, cur_word_d;
  // words still to fetch on the current row; zero means no active row
  logic [5:0]  words_left_q, words_left_d;
  logic [15:0] color_q, color_d;
  logic        underrun_q, underrun_d;

  logic [9:0]  pos_col, pos_row;
  logic [9:0]  hy;
  logic [3:0]  hx_lo;
  logic        row_in, in_win;
  logic        row_start, row_clear, transfer;
  logic [15:0] eff_word, pix_word;
  logic        pix_bit;

  // Position of the pixel being strobed: resync at address 0, else advance raster.
  always_comb begin
    pos_col = col_q;
    pos_row = row_q;
    if (pix_addr == 24'd0) begin
      pos_col = '0;
      pos_row = '0;
    end else if (col_q == H_MAX) begin
      pos_col = '0;
      pos_row = (row_q == V_MAX) ? '0 : row_q + 10'd1;
    end else begin
      pos_col = col_q + 10'd1;
    end
  end

  // Window decode and the pixel bit selected from the current or incoming word.
  always_comb begin
    row_in    = (pos_row >= Y_LO) && (pos_row < Y_HI);
    in_win    = row_in && (pos_col >= X_LO) && (pos_col < X_HI);
    hy        = pos_row - Y_LO;
    hx_lo     = 4'(pos_col - X_LO);
    row_start = pix_stb && (pos_col == 10'd0) && row_in;
    row_clear = pix_stb && (pos_col == 10'd0) && !row_in;
    transfer  = pix_stb && in_win && (hx_lo == 4'd0);
    // an empty prefetch slot at a word boundary yields a blank word
    eff_word  = next_valid_q ? next_word_q : 16'h0000;
    pix_word  = (hx_lo == 4'd0) ? eff_word : cur_word_q;
    pix_bit   = pix_word[hx_lo];
  end

  // Fetch FSM next state: one read per empty slot while the row has words left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!next_valid_q && (words_left_q != 6'd0)) state_d = ST_REQ;
      ST_REQ:  state_d = ST_CAP;
      ST_CAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: position, prefetch slot, word handover, colour.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    next_addr_d  = next_addr_q;
    next_word_d  = next_word_q;
    next_valid_d = next_valid_q;
    cur_word_d   = cur_word_q;
    words_left_d = words_left_q;
    color_d      = color_q;
    underrun_d   = underrun_q;

    if (pix_stb) begin
      col_d   = pos_col;
      row_d   = pos_row;
      color_d = in_win ? (pix_bit ? FG : BG) : BORDER;
    end

    if (transfer) begin
      cur_word_d   = eff_word;
      next_valid_d = 1'b0;
      next_addr_d  = next_addr_q + 13'd1;
      if (!next_valid_q) underrun_d = 1'b1;
    end

    // a completing fetch refills the slot even if a handover emptied it this cycle
    if (state_q == ST_CAP) begin
      next_word_d  = mem_data;
      next_valid_d = 1'b1;
      words_left_d = words_left_q - 6'd1;
    end

    // row start overrides a same-cycle capture; that data belongs to the old row
    if (row_start) begin
      next_addr_d  = 13'(hy) * 13'(WORDS);
      next_valid_d = 1'b0;
      words_left_d = WORDS;
    end else if (row_clear) begin
      next_valid_d = 1'b0;
      words_left_d = 6'd0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      next_addr_q  <= '0;
      next_word_q  <= '0;
      next_valid_q <= 1'b0;
      cur_word_q   <= '0;
      words_left_q <= '0;
      color_q      <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      next_addr_q  <= next_addr_d;
      next_word_q  <= next_word_d;
      next_valid_q <= next_valid_d;
      cur_word_q   <= cur_word_d;
      words_left_q <= words_left_d;
      color_q      <= color_d;
      underrun_q   <= underrun_d;
    end
  end

  assign mem_rd   = (state_q == ST_REQ);
  assign mem_addr = next_addr_q;
  assign color    = color_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_screen_pixel_fetch.sv
// Directed bench for screen_pixel_fetch. u_a uses the full 640x480 raster and
// covers reset and border behaviour; u_b uses a scaled-down raster
// (40x12, window 32x8 at col 3, row 2) so that window rows, the last word,
// frame wrap, reset mid-fetch and a forced underrun fit in a short run.
module tb_screen_pixel_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        pix_stb_a = 1'b0;
  logic [23:0] pix_addr_a = '0;
  logic [12:0] mem_addr_a;
  logic        mem_rd_a;
  logic [15:0] mem_data_a = '0;
  logic [15:0] color_a;
  logic        underrun_a;

  logic        pix_stb_b = 1'b0;
  logic [23:0] pix_addr_b = '0;
  logic [12:0] mem_addr_b;
  logic        mem_rd_b;
  logic [15:0] mem_data_b = '0;
  logic [15:0] color_b;
  logic        underrun_b;

  int          total = 0;
  int          bad = 0;
  int          rd_cnt_a = 0;
  int          rd_cnt_b = 0;
  logic [12:0] last_addr_b = '0;
  logic        seen15 = 1'b0;

  screen_pixel_fetch u_a (
    .clock(clock), .reset(reset), .pix_stb(pix_stb_a), .pix_addr(pix_addr_a),
    .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
    .color(color_a), .underrun(underrun_a)
  );

  screen_pixel_fetch #(
    .H_ACTIVE(40), .V_ACTIVE(12), .WIN_X(3), .WIN_Y(2), .WIN_W(32), .WIN_H(8)
  ) u_b (
    .clock(clock), .reset(reset), .pix_stb(pix_stb_b), .pix_addr(pix_addr_b),
    .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
    .color(color_b), .underrun(underrun_b)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [12:0] a);
    if (a == 13'd0)  return 16'h0001;
    if (a == 13'd15) return 16'h8000;
    return 16'h5A5A ^ {3'b000, a};
  endfunction

  // Screen RAM models: data presented during the read cycle and held for the next.
  always @(negedge clock) begin
    if (mem_rd_a === 1'b1) begin
      rd_cnt_a = rd_cnt_a + 1;
      mem_data_a = 16'hFFFF;
    end
    if (mem_rd_b === 1'b1) begin
      rd_cnt_b = rd_cnt_b + 1;
      last_addr_b = mem_addr_b;
      mem_data_b = mem_word(mem_addr_b);
      if (mem_addr_b == 13'd15) seen15 = 1'b1;
    end
  end

  task automatic strobe_a(input logic [23:0] addr);
    @(posedge clock); #1;
    pix_stb_a = 1'b1;
    pix_addr_a = addr;
    @(posedge clock); #1;
    pix_stb_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [23:0] addr);
    @(posedge clock); #1;
    pix_stb_b = 1'b1;
    pix_addr_b = addr;
    @(posedge clock); #1;
    pix_stb_b = 1'b0;
  endtask

  task automatic stream_b(input int from, input int to);
    for (int i = from; i <= to; i++) strobe_b(24'(i));
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (color_a !== 16'h0000) begin bad++; $display("FAIL reset_color_a got=%h exp=0000", color_a); end
    total++; if (mem_rd_a !== 1'b0) begin bad++; $display("FAIL reset_mem_rd_a got=%b exp=0", mem_rd_a); end
    total++; if (underrun_a !== 1'b0) begin bad++; $display("FAIL reset_underrun_a got=%b exp=0", underrun_a); end
    total++; if (mem_addr_a !== 13'd0) begin bad++; $display("FAIL reset_mem_addr_a got=%0d exp=0", mem_addr_a); end
    total++; if (color_b !== 16'h0000) begin bad++; $display("FAIL reset_color_b got=%h exp=0000", color_b); end
    total++; if (mem_rd_b !== 1'b0) begin bad++; $display("FAIL reset_mem_rd_b got=%b exp=0", mem_rd_b); end
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    total++; if (rd_cnt_a !== 0) begin bad++; $display("FAIL idle_reads_a got=%0d exp=0", rd_cnt_a); end
    total++; if (rd_cnt_b !== 0) begin bad++; $display("FAIL idle_reads_b got=%0d exp=0", rd_cnt_b); end
  endtask

  task automatic test_border;
    strobe_a(24'd0);
    total++; if (color_a !== 16'h001F) begin bad++; $display("FAIL border_px0 got=%h exp=001F", color_a); end
    strobe_a(24'd1);
    total++; if (color_a !== 16'h001F) begin bad++; $display("FAIL border_px1 got=%h exp=001F", color_a); end
    for (int i = 2; i < 1280; i++) strobe_a(24'(i));
    total++; if (color_a !== 16'h001F) begin bad++; $display("FAIL border_row1_end got=%h exp=001F", color_a); end
    total++; if (rd_cnt_a !== 0) begin bad++; $display("FAIL border_no_reads got=%0d exp=0", rd_cnt_a); end
    total++; if (underrun_a !== 1'b0) begin bad++; $display("FAIL border_underrun got=%b exp=0", underrun_a); end
  endtask

  task automatic test_first_word;
    stream_b(0, 79);
    total++; if (rd_cnt_b !== 0) begin bad++; $display("FAIL fw_no_reads_outside got=%0d exp=0", rd_cnt_b); end
    strobe_b(24'd80);
    total++; if (color_b !== 16'h001F) begin bad++; $display("FAIL fw_col0 got=%h exp=001F", color_b); end
    strobe_b(24'd81);
    total++; if (rd_cnt_b !== 1) begin bad++; $display("FAIL fw_first_read_cnt got=%0d exp=1", rd_cnt_b); end
    total++; if (last_addr_b !== 13'd0) begin bad++; $display("FAIL fw_first_read_addr got=%0d exp=0", last_addr_b); end
    strobe_b(24'd82);
    total++; if (color_b !== 16'h001F) begin bad++; $display("FAIL fw_col2 got=%h exp=001F", color_b); end
    strobe_b(24'd83);
    total++; if (color_b !== 16'h0000) begin bad++; $display("FAIL fw_col3 got=%h exp=0000", color_b); end
    strobe_b(24'd84);
    total++; if (color_b !== 16'hFFFF) begin bad++; $display("FAIL fw_col4 got=%h exp=FFFF", color_b); end
    total++; if (rd_cnt_b !== 2) begin bad++; $display("FAIL fw_second_read_cnt got=%0d exp=2", rd_cnt_b); end
    total++; if (last_addr_b !== 13'd1) begin bad++; $display("FAIL fw_second_read_addr got=%0d exp=1", last_addr_b); end
    repeat (6) @(posedge clock);
    #1;
    total++; if (color_b !== 16'hFFFF) begin bad++; $display("FAIL fw_hold got=%h exp=FFFF", color_b); end
    stream_b(85, 99);
    total++; if (color_b !== 16'h0000) begin bad++; $display("FAIL fw_col19 got=%h exp=0000", color_b); end
    stream_b(100, 101);
    total++; if (color_b !== 16'hFFFF) begin bad++; $display("FAIL fw_col21 got=%h exp=FFFF", color_b); end
    stream_b(102, 114);
    total++; if (color_b !== 16'hFFFF) begin bad++; $display("FAIL fw_col34 got=%h exp=FFFF", color_b); end
    strobe_b(24'd115);
    total++; if (color_b !== 16'h001F) begin bad++; $display("FAIL fw_col35 got=%h exp=001F", color_b); end
  endtask

  task automatic test_last_word;
    stream_b(116, 393);
    total++; if (color_b !== 16'hFFFF) begin bad++; $display("FAIL lw_col33 got=%h exp=FFFF", color_b); end
    strobe_b(24'd394);
    total++; if (color_b !== 16'h0000) begin bad++; $display("FAIL lw_col34 got=%h exp=0000", color_b); end
    strobe_b(24'd395);
    total++; if (color_b !== 16'h001F) begin bad++; $display("FAIL lw_col35 got=%h exp=001F", color_b); end
    total++; if (seen15 !== 1'b1) begin bad++; $display("FAIL lw_last_addr_read got=%b exp=1", seen15); end
    stream_b(396, 479);
    total++; if (rd_cnt_b !== 16) begin bad++; $display("FAIL lw_frame_reads got=%0d exp=16", rd_cnt_b); end
    strobe_b(24'd480);
    total++; if (color_b !== 16'h001F) begin bad++; $display("FAIL lw_wrap_px got=%h exp=001F", color_b); end
    stream_b(481, 563);
    total++; if (color_b !== 16'h0000) begin bad++; $display("FAIL lw_wrap_col3 got=%h exp=0000", color_b); end
    total++; if (rd_cnt_b !== 17) begin bad++; $display("FAIL lw_wrap_reads got=%0d exp=17", rd_cnt_b); end
    total++; if (underrun_b !== 1'b0) begin bad++; $display("FAIL lw_underrun got=%b exp=0", underrun_b); end
  endtask

  task automatic test_reset_mid_fetch;
    int cnt0;
    stream_b(564, 600);
    @(posedge clock); #1;
    total++; if (mem_rd_b !== 1'b1) begin bad++; $display("FAIL rmf_req got=%b exp=1", mem_rd_b); end
    total++; if (mem_addr_b !== 13'd2) begin bad++; $display("FAIL rmf_req_addr got=%0d exp=2", mem_addr_b); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    total++; if (mem_rd_b !== 1'b0) begin bad++; $display("FAIL rmf_rd_drop got=%b exp=0", mem_rd_b); end
    total++; if (color_b !== 16'h0000) begin bad++; $display("FAIL rmf_color got=%h exp=0000", color_b); end
    total++; if (mem_addr_b !== 13'd0) begin bad++; $display("FAIL rmf_addr got=%0d exp=0", mem_addr_b); end
    cnt0 = rd_cnt_b;
    repeat (5) @(posedge clock);
    #1;
    total++; if (rd_cnt_b !== cnt0) begin bad++; $display("FAIL rmf_no_reads got=%0d exp=%0d", rd_cnt_b, cnt0); end
    stream_b(0, 83);
    total++; if (color_b !== 16'h0000) begin bad++; $display("FAIL rmf_col3 got=%h exp=0000", color_b); end
    strobe_b(24'd84);
    total++; if (color_b !== 16'hFFFF) begin bad++; $display("FAIL rmf_col4 got=%h exp=FFFF", color_b); end
  endtask

  task automatic test_underrun;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    stream_b(0, 79);
    @(posedge clock); #1;
    pix_stb_b = 1'b1;
    for (int i = 80; i <= 83; i++) begin
      pix_addr_b = 24'(i);
      @(posedge clock); #1;
    end
    pix_stb_b = 1'b0;
    total++; if (underrun_b !== 1'b1) begin bad++; $display("FAIL ur_flag got=%b exp=1", underrun_b); end
    total++; if (color_b !== 16'hFFFF) begin bad++; $display("FAIL ur_col3 got=%h exp=FFFF", color_b); end
    strobe_b(24'd84);
    total++; if (color_b !== 16'hFFFF) begin bad++; $display("FAIL ur_col4 got=%h exp=FFFF", color_b); end
    stream_b(85, 120);
    total++; if (underrun_b !== 1'b1) begin bad++; $display("FAIL ur_sticky got=%b exp=1", underrun_b); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    total++; if (underrun_b !== 1'b0) begin bad++; $display("FAIL ur_reset_clear got=%b exp=0", underrun_b); end
  endtask

  initial begin
    test_reset();
    test_border();
    test_first_word();
    test_last_word();
    test_reset_mid_fetch();
    test_underrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
